// File: rtl/mem_burst_master_if.sv
// Bundle of command, memory-bus, read-stream and status signals for mem_burst_master.
// Handshake rule for both cmd_* and m_* channels: a transfer happens on a rising
// clock edge where valid && ready are both 1; the initiator holds its payload
// stable while valid=1 and ready=0, and ready may not depend on a later edge.
interface mem_burst_master_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int LEN_WIDTH  = 6,
   parameter int CSUM_WIDTH = 16
) ();
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_wr;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic [WIDTH-1:0]      cmd_seed;

   logic                  m_valid;
   logic                  m_ready;
   logic                  m_wr_rd;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [WIDTH-1:0]      m_wdata;
   logic [WIDTH-1:0]      m_rdata;

   logic                  rd_valid;
   logic [WIDTH-1:0]      rd_data;
   logic                  rd_last;

   logic                  done;
   logic                  err;
   logic [CSUM_WIDTH-1:0] csum;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_seed, m_ready, m_rdata,
      output cmd_ready, m_valid, m_wr_rd, m_addr, m_wdata,
      output rd_valid, rd_data, rd_last, done, err, csum
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_seed, m_ready, m_rdata,
      input  cmd_ready, m_valid, m_wr_rd, m_addr, m_wdata,
      input  rd_valid, rd_data, rd_last, done, err, csum
   );
endinterface

// File: rtl/mem_burst_master.sv
// Burst master: splits one command into single-beat memory transactions,
// generates incrementing write data, streams read data, accumulates a checksum
// and reports completion or a per-beat timeout.
module mem_burst_master #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
   parameter int TIMEOUT    = 16,
   parameter int CSUM_WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   mem_burst_master_if.master  bus,
   output logic [1:0]          o_dbg_state
);
   localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_beat;
   logic [WD_WIDTH-1:0]   r_wdog;
   logic [CSUM_WIDTH-1:0] r_csum;
   logic                  r_cmd_ready;
   logic                  r_m_valid;
   logic                  r_m_wr_rd;
   logic [ADDR_WIDTH-1:0] r_m_addr;
   logic [WIDTH-1:0]      r_m_wdata;
   logic                  r_rd_valid;
   logic [WIDTH-1:0]      r_rd_data;
   logic                  r_rd_last;
   logic                  r_done;
   logic                  r_err;

   logic                  w_last;
   logic                  w_wd_expire;
   logic [WIDTH-1:0]      w_beat_data;
   logic [ADDR_WIDTH-1:0] w_next_addr;

   // Beat bookkeeping derived from the registered bus state.
   assign w_last      = (r_beat == r_len - LEN_WIDTH'(1));
   assign w_wd_expire = (r_wdog == WD_WIDTH'(TIMEOUT - 1));
   assign w_beat_data = r_m_wr_rd ? r_m_wdata : bus.m_rdata;
   // Explicit wrap so non-power-of-two depths still roll from DEPTH-1 to 0.
   assign w_next_addr = (r_m_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_m_addr + ADDR_WIDTH'(1);

   // Single FSM: all outputs are registers updated alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_beat      <= '0;
         r_wdog      <= '0;
         r_csum      <= '0;
         r_cmd_ready <= 1'b1;
         r_m_valid   <= 1'b0;
         r_m_wr_rd   <= 1'b0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_rd_last   <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  // The address/data registers double as the latched start/seed.
                  r_len       <= bus.cmd_len;
                  r_m_wr_rd   <= bus.cmd_wr;
                  r_m_addr    <= bus.cmd_addr;
                  r_m_wdata   <= bus.cmd_seed;
                  r_beat      <= '0;
                  r_csum      <= '0;
                  r_wdog      <= '0;
                  r_err       <= 1'b0;
                  r_cmd_ready <= 1'b0;
                  if (bus.cmd_len == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_ISSUE;
                     r_m_valid <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.m_ready) begin
                  r_beat <= r_beat + LEN_WIDTH'(1);
                  r_csum <= r_csum + CSUM_WIDTH'(w_beat_data);
                  r_wdog <= '0;
                  if (!r_m_wr_rd) begin
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= bus.m_rdata;
                     r_rd_last  <= w_last;
                  end
                  if (w_last) begin
                     r_state   <= S_DONE;
                     r_m_valid <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_m_addr  <= w_next_addr;
                     r_m_wdata <= r_m_wdata + WIDTH'(1);
                  end
               end else if (w_wd_expire) begin
                  r_state   <= S_DONE;
                  r_m_valid <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + WD_WIDTH'(1);
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
               r_m_valid   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.m_valid   = r_m_valid;
   assign bus.m_wr_rd   = r_m_wr_rd;
   assign bus.m_addr    = r_m_addr;
   assign bus.m_wdata   = r_m_wdata;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = r_rd_data;
   assign bus.rd_last   = r_rd_last;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.csum      = r_csum;
   assign o_dbg_state   = r_state;
endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Command-driven bus master sitting directly upstream of the single-port valid/ready memory. It accepts one burst command at a time (start address, length, direction, data seed) and breaks it into single-beat memory transactions. For writes it generates an incrementing data pattern; for reads it streams returned data out. For both directions it accumulates a checksum and reports completion or timeout.

## Interface
Parameters:
- WIDTH, 8, data width; equals memory WIDTH
- DEPTH, 32, memory depth in words
- ADDR_WIDTH, $clog2(DEPTH), memory address width
- LEN_WIDTH, ADDR_WIDTH+1, burst length field width; lengths 0..DEPTH
- TIMEOUT, 16, max cycles to wait for m_ready per beat
- CSUM_WIDTH, 16, checksum width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  number of beats
- cmd_seed  in  WIDTH  first write data word; ignored for reads
- m_valid  out  1  memory request valid
- m_ready  in  1  memory accepts / completes request
- m_wr_rd  out  1  1 = write, 0 = read
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  WIDTH  memory write data
- m_rdata  in  WIDTH  memory read data; valid in the cycle m_valid&&m_ready on a read
- rd_valid  out  1  one-cycle pulse per read beat
- rd_data  out  WIDTH  read beat data
- rd_last  out  1  marks final read beat, qualified by rd_valid
- done  out  1  one-cycle burst-complete pulse
- err  out  1  timeout flag, qualified by done
- csum  out  CSUM_WIDTH  burst checksum; stable from done until next command accepted

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: cmd_ready=1, m_valid=0.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields, clear csum and beat counter.
  - Next state ISSUE, or DONE directly if cmd_len==0.
- ISSUE: cmd_ready=0, m_valid=1; m_wr_rd = latched cmd_wr; m_addr = (start + beat) mod DEPTH, wrapping past DEPTH-1 to 0.
  - Write data is m_wdata = (seed + beat) mod 2^WIDTH.
  - A beat transfers on a rising edge where m_valid&&m_ready. On transfer:
    - beat counter increments
    - csum += zero-extended beat data (m_wdata for writes, m_rdata for reads), mod 2^CSUM_WIDTH
    - for reads, m_rdata is captured into rd_data
  - m_addr, m_wdata and m_wr_rd hold stable while m_valid=1 and m_ready=0.
  - The last beat transfers when beat == len-1. Next state is DONE.
  - Watchdog: counter cleared on every transfer and on entry to ISSUE; increments each ISSUE cycle without m_ready. If it reaches TIMEOUT, m_valid drops and the next state is DONE with err=1. csum covers completed beats only.
- DONE: one cycle; done=1, err as recorded (0 if not timed out); m_valid=0, cmd_ready=0. Next state IDLE.
- Commands presented outside IDLE are not accepted (cmd_ready=0); the source must hold them.

## Timing
- Reset (rst=0, async): state IDLE. Outputs:
  - cmd_ready=1
  - m_valid=0, m_wr_rd=0, m_addr=0, m_wdata=0
  - rd_valid=0, rd_data=0, rd_last=0
  - done=0, err=0, csum=0
- Reset asserted mid-burst abandons the burst immediately: no done pulse, no further beats.
- Command accepted at edge N → m_valid=1 from cycle N+1.
- Back-to-back beats: with m_ready held 1, one beat per cycle; the next address/data is presented the cycle after each transfer. An L-beat burst occupies L ISSUE cycles.
- rd_valid/rd_data/rd_last are registered: they pulse in the cycle after the read transfer edge.
- done asserts the cycle after the final transfer (or timeout) edge. For reads, the final rd_valid with rd_last=1 coincides with done.
- cmd_ready returns to 1 the cycle after done; new command earliest 2 cycles after the final transfer.
- cmd_len==0: done=1, err=0, csum=0 the cycle after acceptance; no m_valid.
- Timeout counts cycles with m_valid=1 and m_ready=0. The TIMEOUT-th such consecutive cycle ends ISSUE.

## Test plan
- Reset: hold rst=0 for 2 cycles → all outputs at reset values, cmd_ready=1.
- Write burst: addr=0, len=32, seed=8'h50, m_ready tied 1 → 32 consecutive beats, m_wdata 0x50..0x6F; done at cycle 33, err=0, csum=16'h0BF0.
- Wrap read: addr=30, len=4, memory preloaded → m_addr sequence 30,31,0,1; four rd_valid pulses, rd_last on the 4th coinciding with done; csum equals the sum of the returned words.
- Backpressure: m_ready toggling 1-in-3 during 5-beat write → address/data held stable while stalled; 5 transfers total; err=0.
- Timeout: m_ready stuck 0, TIMEOUT=16, len=3 → m_valid drops after 16 cycles; done=1, err=1, csum=0. A subsequent command is accepted normally.
- Corner cases:
  - len=0 → done one cycle after acceptance with no m_valid.
  - rst pulsed low mid-burst → outputs reset asynchronously; no done pulse.
